// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - request size encodings (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_BAD)
//   - FSM state enumeration
//   - lane-offset constants (byte lane number -> bit offset in the word)
//   - access_err(): misalignment / illegal-size detection
// ---------------------------------------------------------------------------
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_BAD  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // Bit offset of each byte lane inside a 32-bit word.
   localparam logic [4:0] LANE0_LSB = 5'd0;
   localparam logic [4:0] LANE1_LSB = 5'd8;
   localparam logic [4:0] LANE2_LSB = 5'd16;
   localparam logic [4:0] LANE3_LSB = 5'd24;

   // High when the request must be rejected without touching memory.
   function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
      logic err;
      err = 1'b0;
      case (size)
         SZ_HALF: err = lane[0];
         SZ_WORD: err = (lane != 2'b00);
         SZ_BAD:  err = 1'b1;
         default: err = 1'b0;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane datapath of the load/store unit.
//   size        in  access size (lsu_pkg SZ_* encoding)
//   is_unsigned in  loads: 1 = zero-extend, 0 = sign-extend
//   lane        in  byte offset inside the word (addr[1:0])
//   rd_word     in  word read from memory (load path source)
//   base_word   in  previously read word (store merge base)
//   wdata       in  right-aligned store data
//   load_data   out extracted and extended load result
//   store_word  out word to write back (merged for sub-word, wdata for word)
// ---------------------------------------------------------------------------
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [1:0]       size,
   input  logic             is_unsigned,
   input  logic [1:0]       lane,
   input  logic [WIDTH-1:0] rd_word,
   input  logic [WIDTH-1:0] base_word,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] store_word
);

   logic [4:0]  byte_lsb;
   logic [4:0]  half_lsb;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Halves sit on lane 0 or lane 2; lane[0] is irrelevant for them.
   always_comb begin
      byte_lsb = LANE0_LSB;
      case (lane)
         2'd1:    byte_lsb = LANE1_LSB;
         2'd2:    byte_lsb = LANE2_LSB;
         2'd3:    byte_lsb = LANE3_LSB;
         default: byte_lsb = LANE0_LSB;
      endcase
      half_lsb = lane[1] ? LANE2_LSB : LANE0_LSB;
   end

   always_comb begin
      byte_sel  = rd_word[byte_lsb +: 8];
      half_sel  = rd_word[half_lsb +: 16];
      load_data = rd_word;
      case (size)
         SZ_BYTE: load_data = {{(WIDTH-8){~is_unsigned & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_data = {{(WIDTH-16){~is_unsigned & half_sel[15]}}, half_sel};
         default: load_data = rd_word;
      endcase
   end

   always_comb begin
      store_word = wdata;
      case (size)
         SZ_BYTE: begin
            store_word = base_word;
            store_word[byte_lsb +: 8] = wdata[7:0];
         end
         SZ_HALF: begin
            store_word = base_word;
            store_word[half_lsb +: 16] = wdata[15:0];
         end
         default: store_word = wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Initiator side of the word-organised data-memory port. Handles byte, half
// and word loads/stores; sub-word stores are done as read-modify-write.
// Misaligned or illegal-size requests complete with rsp_err and never touch
// memory.
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   rsp_valid         one-cycle completion pulse (no backpressure)
//   rsp_rdata/rsp_err load data / error flag, valid with rsp_valid
//   mem_we/addr/wd    memory write enable, word address, write data
//   mem_rd            memory read data, combinational from mem_addr
// ---------------------------------------------------------------------------
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   input  logic [31:0]      req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             rsp_err,
   output logic             mem_we,
   output logic [DEPTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wd,
   input  logic [WIDTH-1:0] mem_rd
);

   state_t           state_reg;
   state_t           state_next;
   logic             we_reg;
   logic [1:0]       size_reg;
   logic             uns_reg;
   logic [DEPTH+1:0] addr_reg;
   logic [WIDTH-1:0] wdata_reg;
   logic [WIDTH-1:0] rd_word_reg;
   logic [WIDTH-1:0] rsp_rdata_reg;
   logic             rsp_err_reg;

   logic             accept;
   logic             req_err;
   logic [WIDTH-1:0] load_data;
   logic [WIDTH-1:0] store_word;

   // Address bits above the word index wrap away by design.
   logic             unused_addr_bits;
   assign unused_addr_bits = ^req_addr[31:DEPTH+2];

   assign accept  = (state_reg == ST_IDLE) && req_valid;
   assign req_err = access_err(req_size, req_addr[1:0]);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_err)
                  state_next = ST_RESP;
               else if (req_we && (req_size == SZ_WORD))
                  state_next = ST_WRITE;
               else
                  state_next = ST_READ;   // loads and sub-word stores
            end
         end
         ST_READ:  state_next = we_reg ? ST_WRITE : ST_RESP;
         ST_WRITE: state_next = ST_RESP;
         ST_RESP:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= ST_IDLE;
         we_reg        <= 1'b0;
         size_reg      <= SZ_BYTE;
         uns_reg       <= 1'b0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         rd_word_reg   <= '0;
         rsp_rdata_reg <= '0;
         rsp_err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            we_reg        <= req_we;
            size_reg      <= req_size;
            uns_reg       <= req_unsigned;
            addr_reg      <= req_addr[DEPTH+1:0];
            wdata_reg     <= req_wdata;
            rsp_err_reg   <= req_err;
            rsp_rdata_reg <= '0;      // stays 0 for stores and errors
         end
         if (state_reg == ST_READ) begin
            rd_word_reg <= mem_rd;
            if (!we_reg)
               rsp_rdata_reg <= load_data;
         end
      end
   end

   lsu_lane_align #(.WIDTH(WIDTH)) u_align (
      .size        (size_reg),
      .is_unsigned (uns_reg),
      .lane        (addr_reg[1:0]),
      .rd_word     (mem_rd),
      .base_word   (rd_word_reg),
      .wdata       (wdata_reg),
      .load_data   (load_data),
      .store_word  (store_word)
   );

   // Decoded straight from the state register so that mem_we falls together
   // with an asynchronous reset, abandoning any pending write.
   assign req_ready = (state_reg == ST_IDLE);
   assign rsp_valid = (state_reg == ST_RESP);
   assign rsp_rdata = rsp_rdata_reg;
   assign rsp_err   = rsp_err_reg;
   assign mem_we    = (state_reg == ST_WRITE);
   assign mem_wd    = mem_we ? store_word : '0;
   assign mem_addr  = addr_reg[DEPTH+1:2];

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

   logic             clk;
   logic             reset_n;
   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [1:0]       req_size;
   logic             req_unsigned;
   logic [31:0]      req_addr;
   logic [31:0]      req_wdata;
   logic             rsp_valid;
   logic [31:0]      rsp_rdata;
   logic             rsp_err;
   logic             mem_we;
   logic [DEPTH-1:0] mem_addr;
   logic [31:0]      mem_wd;
   logic [31:0]      mem_rd;

   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];
   logic        clr;

   int n_cmp;
   int n_bad;
   int n_txn;

   load_store_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wd       (mem_wd),
      .mem_rd       (mem_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: combinational read, write at the rising edge.
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wd;
      end
   end
   assign mem_rd = mem[mem_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // One request, starting in an IDLE cycle (called just after a falling edge).
   task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] got_rdata);
      int          idx, sh, exp_lat, got_lat, we_cnt, we_cyc, exp_we_cyc;
      logic        exp_err;
      logic [31:0] w, v, exp_rdata;
      idx     = int'((addr >> 2) & 32'hFF);
      exp_err = (size == X) || (size == H && addr[0]) || (size == W && addr[1:0] != 2'b00);
      exp_rdata = 32'h0;
      w = ref_mem[idx];
      if (!exp_err) begin
         if (size == B) begin
            sh = 8 * int'(addr & 3);
            if (we) ref_mem[idx] = (w & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
            else begin
               v = (w >> sh) & 32'hFF;
               exp_rdata = (!uns && v[7]) ? (v | 32'hFFFF_FF00) : v;
            end
         end else if (size == H) begin
            sh = 8 * int'(addr & 2);
            if (we) ref_mem[idx] = (w & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
            else begin
               v = (w >> sh) & 32'hFFFF;
               exp_rdata = (!uns && v[15]) ? (v | 32'hFFFF_0000) : v;
            end
         end else begin
            if (we) ref_mem[idx] = wdata;
            else exp_rdata = w;
         end
      end
      exp_lat    = exp_err ? 1 : ((!we || size == W) ? 2 : 3);
      exp_we_cyc = (we && !exp_err) ? exp_lat - 1 : 0;

      check("ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;

      got_lat = 0; we_cnt = 0; we_cyc = 0; got_rdata = 32'hX;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         check("ready_busy", 32'(req_ready), 32'd0);
         if (mem_we) begin
            we_cnt++;
            we_cyc = k;
            check("mem_wd", mem_wd, ref_mem[idx]);
            check("mem_addr", 32'(mem_addr), 32'(idx));
         end else begin
            check("mem_wd_idle", mem_wd, 32'h0);
         end
         if (rsp_valid) begin
            got_lat   = k;
            got_rdata = rsp_rdata;
            check("rsp_rdata", rsp_rdata, exp_rdata);
            check("rsp_err", 32'(rsp_err), 32'(exp_err));
            break;
         end
      end
      check("latency", 32'(got_lat), 32'(exp_lat));
      check("we_count", 32'(we_cnt), (we && !exp_err) ? 32'd1 : 32'd0);
      check("we_cycle", 32'(we_cyc), 32'(exp_we_cyc));
      @(negedge clk);
      check("mem_word", mem[idx], ref_mem[idx]);
      check("rsp_gone", 32'(rsp_valid), 32'd0);
      n_txn++;
      $display("txn %0d: we=%0b size=%0d uns=%0b addr=%08h wdata=%08h -> rdata=%08h err=%0b lat=%0d",
               n_txn, we, size, uns, addr, wdata, got_rdata, rsp_err, got_lat);
   endtask

   task automatic reset_abort_test();
      check("ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = 1'b1; req_size = B; req_unsigned = 1'b0;
      req_addr = 32'h41; req_wdata = 32'h5A;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rst_read_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      check("rst_write_we", 32'(mem_we), 32'd1);
      reset_n = 1'b0;
      #1;
      check("rst_we_async", 32'(mem_we), 32'd0);
      check("rst_wd_async", mem_wd, 32'h0);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_addr", 32'(mem_addr), 32'h0);
      repeat (2) @(negedge clk);
      check("rst_rspv", 32'(rsp_valid), 32'd0);
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("post_rst_rspv", 32'(rsp_valid), 32'd0);
         check("post_rst_ready", 32'(req_ready), 32'd1);
      end
      check("rst_mem_untouched", mem[16], 32'h0);
      n_txn++;
      $display("txn %0d: byte store @00000041 aborted by reset in WRITE", n_txn);
   endtask

   // Loads with req_valid held high: one accept per IDLE cycle, 3-cycle period.
   task automatic held_valid_test();
      int n_rsp;
      n_rsp = 0;
      req_valid = 1'b1; req_we = 1'b0; req_size = W; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      for (int k = 0; k < 12; k++) begin
         check("held_ready", 32'(req_ready), (k % 3 == 0) ? 32'd1 : 32'd0);
         check("held_rspv", 32'(rsp_valid), (k % 3 == 2) ? 32'd1 : 32'd0);
         if (rsp_valid) begin
            n_rsp++;
            check("held_rdata", rsp_rdata, ref_mem[0]);
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      check("held_rsp_count", 32'(n_rsp), 32'd4);
      n_txn++;
      $display("txn %0d: 4 back-to-back word loads @00000000 with valid held, %0d responses", n_txn, n_rsp);
   endtask

   logic [31:0] rd;

   initial begin
      n_cmp = 0; n_bad = 0; n_txn = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
      reset_n = 1'b0; clr = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = B; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      repeat (2) @(negedge clk);
      check("reset_ready", 32'(req_ready), 32'd1);
      check("reset_rspv", 32'(rsp_valid), 32'd0);
      check("reset_rdata", rsp_rdata, 32'h0);
      check("reset_err", 32'(rsp_err), 32'd0);
      check("reset_we", 32'(mem_we), 32'd0);
      check("reset_addr", 32'(mem_addr), 32'h0);
      check("reset_wd", mem_wd, 32'h0);
      clr = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);

      do_txn(1'b1, W, 1'b0, 32'h10, 32'hDEAD_BEEF, rd);
      do_txn(1'b0, W, 1'b0, 32'h10, 32'h0, rd);
      check("word_load", rd, 32'hDEAD_BEEF);

      do_txn(1'b1, W, 1'b0, 32'h10, 32'h1122_3344, rd);
      do_txn(1'b1, B, 1'b0, 32'h13, 32'hA5, rd);
      check("byte_merge", mem[4], 32'hA522_3344);
      do_txn(1'b0, B, 1'b0, 32'h13, 32'h0, rd);
      check("lb_signed", rd, 32'hFFFF_FFA5);
      do_txn(1'b0, B, 1'b1, 32'h13, 32'h0, rd);
      check("lb_unsigned", rd, 32'h0000_00A5);

      do_txn(1'b1, W, 1'b0, 32'h20, 32'h8001_7FFF, rd);
      do_txn(1'b0, H, 1'b0, 32'h22, 32'h0, rd);
      check("lh_signed", rd, 32'hFFFF_8001);
      do_txn(1'b0, H, 1'b1, 32'h22, 32'h0, rd);
      check("lh_unsigned", rd, 32'h0000_8001);
      do_txn(1'b0, H, 1'b0, 32'h20, 32'h0, rd);
      check("lh_low", rd, 32'h0000_7FFF);

      do_txn(1'b0, W, 1'b0, 32'h0E, 32'h0, rd);
      do_txn(1'b0, H, 1'b0, 32'h11, 32'h0, rd);
      do_txn(1'b1, X, 1'b0, 32'h10, 32'hFFFF_FFFF, rd);
      do_txn(1'b1, H, 1'b0, 32'h23, 32'hBEEF, rd);

      reset_abort_test();
      do_txn(1'b0, W, 1'b0, 32'h40, 32'h0, rd);
      check("after_abort", rd, 32'h0);

      do_txn(1'b1, W, 1'b0, 32'h400, 32'h1234_5678, rd);
      check("wrap_word0", mem[0], 32'h1234_5678);
      held_valid_test();

      for (int t = 0; t < 60; t++) begin
         logic        we, uns;
         logic [1:0]  size;
         logic [31:0] addr, hi;
         we   = 1'($urandom_range(0, 1));
         uns  = 1'($urandom_range(0, 1));
         size = 2'($urandom_range(0, 3));
         hi   = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FC00) : 32'h0;
         addr = hi | ($urandom_range(32, 47) << 2) | $urandom_range(0, 3);
         do_txn(we, size, uns, addr, $urandom, rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
